ml_ahb_arb_port_0: RTL and testbench
====================================

ML_AHB_ARB_PORT_0 -- requirements
Module: ml_ahb_arb_port_0

Interface
REQ-001 Parameters: none; port 0 serves exactly 2 masters (master 0, master 1).
REQ-002 HCLK  in  1  sole clock; all state updates on rising edge.
REQ-003 HRESETn  in  1  reset, synchronous, active-low.
REQ-004 req  in  2  bus request per master, bit n = master n.
REQ-005 prio  in  6  priorities: [2:0] master 0, [5:3] master 1; lower value = higher priority.
REQ-006 htrans_m0, htrans_m1  in  2 each  HTRANS of each master's address phase.
REQ-007 hburst_m0, hburst_m1  in  3 each  HBURST of each master.
REQ-008 hmastlock_m0, hmastlock_m1  in  1 each  locked-sequence indication.
REQ-009 HREADY  in  1  port-level HREADY (transfer completion) from slave side.
REQ-010 addr_sel  out  2  one-hot address-phase owner (00 = no owner).
REQ-011 data_sel  out  2  one-hot data-phase owner (00 = no active data phase).
REQ-012 burst_cnt  out  4  remaining beats of current fixed-length burst.

Function
REQ-013 Winner rule: master 1 wins iff both request and prio[5:3] < prio[2:0]; ties and master-0-only requests give master 0.
REQ-014 States: IDLE (addr_sel=00) and OWNED (addr_sel one-hot, held).
REQ-015 IDLE: if req!=00, next cycle go OWNED with addr_sel = winner; HREADY not required; latency exactly 1 cycle.
REQ-016 Owner signals (htrans/hburst/hmastlock) are those of the master selected by addr_sel.
REQ-017 Accepted beat = HREADY=1 and owner htrans NONSEQ or SEQ.
REQ-018 On accepted NONSEQ: burst_cnt loads len-1 (SINGLE/INCR 0, INCR4/WRAP4 3, INCR8/WRAP8 7, INCR16/WRAP16 15); on accepted SEQ with fixed burst: decrement; burst_cnt never wraps below 0.
REQ-019 Rearbitration point (RP) = HREADY=1, owner hmastlock=0, and one of: owner htrans IDLE; accepted NONSEQ with SINGLE; accepted SEQ of fixed burst with burst_cnt=1 before decrement; owner htrans IDLE/BUSY with owner req=0 under INCR.
REQ-020 INCR (undefined length) ownership held until owner drives IDLE (or BUSY with req=0) at HREADY=1.
REQ-021 At RP: req=00 -> IDLE next cycle; else addr_sel = winner over current req next cycle (owner may re-win).
REQ-022 HREADY=0: addr_sel, data_sel, burst_cnt, state all hold.
REQ-023 hmastlock=1 on owner blocks every RP, including competing higher-priority request.
REQ-024 data_sel: on HREADY=1 loads addr_sel if beat accepted, else 00; holds on HREADY=0.
REQ-025 Owner req dropping mid fixed burst does not release the bus before the burst's RP.
REQ-026 Simultaneous req arrival and RP: single arbitration using that cycle's req/prio.
REQ-027 addr_sel and data_sel always one-hot or 00; never 11.

Reset
REQ-028 HRESETn=0 at a rising edge: state IDLE, addr_sel=00, data_sel=00, burst_cnt=0, regardless of transfer in progress.
REQ-029 First arbitration possible in cycle after HRESETn samples 1.

Structure
REQ-030 Shared package ml_ahb_pkg holds HTRANS codes (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11), HBURST codes, and burst-length mapping function.
REQ-031 Winner computed by instantiating existing ml_ahb_prio_port_0 (prio in, 2-bit decod out), masked by req; no other sub-modules.
REQ-032 All outputs driven directly from flops.

Verification
REQ-033 Reset mid INCR8 beat 4 -> next cycle addr_sel=00, data_sel=00, burst_cnt=0.
REQ-034 IDLE, req=11, prio m0=3 m1=3 -> addr_sel=01 next cycle; with m0=3 m1=2 -> 10.
REQ-035 M0 owns INCR4, m1 requests prio 0 at beat 2 -> m0 keeps bus for 4 accepted beats, addr_sel=10 cycle after last beat accepted.
REQ-036 HREADY=0 for 3 cycles mid-burst -> addr_sel, data_sel, burst_cnt unchanged throughout.
REQ-037 M1 hmastlock=1 over two SINGLE transfers, m0 requesting with better prio -> no handover until hmastlock=0 and RP.
REQ-038 M0 INCR, drops req, drives IDLE with HREADY=1, req=00 -> IDLE next cycle; data_sel=00 one cycle after last data phase.

Source files
------------

// File: rtl/ml_ahb_pkg.sv
// ml_ahb_pkg
// Shared AHB definitions for the multi-layer arbiter ports:
//   - HTRANS and HBURST encodings
//   - arbiter port state type (also used for the state debug output)
//   - helpers mapping HBURST to its beat count and fixed-length flag
package ml_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    // Beats remaining after the NONSEQ beat of a burst (length - 1).
    // Undefined-length INCR has no known length, so it loads 0 like SINGLE.
    function automatic logic [3:0] burst_len_m1(input logic [2:0] hburst);
        logic [3:0] len_m1;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  len_m1 = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  len_m1 = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: len_m1 = 4'd15;
            default:                      len_m1 = 4'd0;
        endcase
        return len_m1;
    endfunction

    // True for bursts of a fixed beat count greater than one.
    function automatic logic burst_is_fixed(input logic [2:0] hburst);
        return (hburst != HBURST_SINGLE) && (hburst != HBURST_INCR);
    endfunction

endpackage

// File: rtl/ml_ahb_prio_port_0.sv
// ml_ahb_prio_port_0
// Priority decoder for the two masters of port 0, assuming both request.
// Lower priority value wins; a tie goes to master 0.
//   prio  [5:0] in  : [2:0] master 0 priority, [5:3] master 1 priority
//   decod [1:0] out : one-hot preferred master (01 = master 0, 10 = master 1)
module ml_ahb_prio_port_0 (
    input  logic [5:0] prio,
    output logic [1:0] decod
);

    always_comb begin
        decod = 2'b01;
        if (prio[5:3] < prio[2:0]) begin
            decod = 2'b10;
        end
    end

endmodule

// File: rtl/ml_ahb_arb_port_0.sv
// ml_ahb_arb_port_0
// AHB multi-layer slave-port arbiter for two masters.
// Grants the address phase to one master, tracks the data-phase owner and
// the remaining beats of fixed-length bursts, and only re-arbitrates at
// burst boundaries (rearbitration points) unless the owner holds HMASTLOCK.
//
// Handshake: a beat is transferred when HREADY=1 and the owner drives
// NONSEQ or SEQ; while HREADY=0 every piece of state holds.
//
// Ports:
//   HCLK, HRESETn              : clock, synchronous active-low reset
//   req[1:0]                   : per-master bus request
//   prio[5:0]                  : per-master priority, lower value wins
//   htrans_m*/hburst_m*        : each master's address-phase controls
//   hmastlock_m*               : each master's locked-sequence flag
//   HREADY                     : port-level transfer completion
//   addr_sel[1:0]              : one-hot address-phase owner, 00 = none
//   data_sel[1:0]              : one-hot data-phase owner, 00 = none
//   burst_cnt[3:0]             : remaining beats of the fixed burst
//   state_dbg                  : arbiter state, for observation only
module ml_ahb_arb_port_0
    import ml_ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [1:0] req,
    input  logic [5:0] prio,
    input  logic [1:0] htrans_m0,
    input  logic [1:0] htrans_m1,
    input  logic [2:0] hburst_m0,
    input  logic [2:0] hburst_m1,
    input  logic       hmastlock_m0,
    input  logic       hmastlock_m1,
    input  logic       HREADY,
    output logic [1:0] addr_sel,
    output logic [1:0] data_sel,
    output logic [3:0] burst_cnt,
    output arb_state_e state_dbg
);

    arb_state_e state_q, state_d;
    logic [1:0] addr_sel_q, addr_sel_d;
    logic [1:0] data_sel_q, data_sel_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;

    logic [1:0] prio_decod;
    logic [1:0] winner;
    logic [1:0] own_htrans;
    logic [2:0] own_hburst;
    logic       own_lock;
    logic       own_req;
    logic       owned;
    logic       beat_ok;
    logic       rp;

    ml_ahb_prio_port_0 u_prio (
        .prio  (prio),
        .decod (prio_decod)
    );

    // The decoder assumes both masters compete; a lone requester wins outright.
    always_comb begin
        winner = req;
        if (req == 2'b11) begin
            winner = prio_decod;
        end
    end

    // Owner-side controls, muxed by the current address-phase owner.
    always_comb begin
        own_htrans = htrans_m0;
        own_hburst = hburst_m0;
        own_lock   = hmastlock_m0;
        if (addr_sel_q[1]) begin
            own_htrans = htrans_m1;
            own_hburst = hburst_m1;
            own_lock   = hmastlock_m1;
        end
        own_req = |(req & addr_sel_q);
    end

    always_comb begin
        owned   = (state_q == ARB_OWNED);
        beat_ok = HREADY && owned &&
                  ((own_htrans == HTRANS_NONSEQ) || (own_htrans == HTRANS_SEQ));
        // Rearbitration points: the owner is idle, a SINGLE completes, the
        // final beat of a fixed burst completes, or an INCR owner parks with
        // BUSY after withdrawing its request. A locked owner never yields.
        rp = HREADY && owned && !own_lock &&
             ((own_htrans == HTRANS_IDLE) ||
              (beat_ok && (own_htrans == HTRANS_NONSEQ) &&
               (own_hburst == HBURST_SINGLE)) ||
              (beat_ok && (own_htrans == HTRANS_SEQ) &&
               burst_is_fixed(own_hburst) && (burst_cnt_q == 4'd1)) ||
              ((own_htrans == HTRANS_BUSY) && !own_req &&
               (own_hburst == HBURST_INCR)));
    end

    always_comb begin
        state_d     = state_q;
        addr_sel_d  = addr_sel_q;
        data_sel_d  = data_sel_q;
        burst_cnt_d = burst_cnt_q;

        case (state_q)
            ARB_IDLE: begin
                // Granting from idle does not wait for HREADY.
                if (req != 2'b00) begin
                    state_d    = ARB_OWNED;
                    addr_sel_d = winner;
                end
            end
            ARB_OWNED: begin
                if (rp) begin
                    if (req == 2'b00) begin
                        state_d    = ARB_IDLE;
                        addr_sel_d = 2'b00;
                    end else begin
                        addr_sel_d = winner;
                    end
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                addr_sel_d = 2'b00;
            end
        endcase

        if (HREADY) begin
            data_sel_d = beat_ok ? addr_sel_q : 2'b00;
        end

        if (beat_ok) begin
            if (own_htrans == HTRANS_NONSEQ) begin
                burst_cnt_d = burst_len_m1(own_hburst);
            end else if (burst_is_fixed(own_hburst) && (burst_cnt_q != 4'd0)) begin
                burst_cnt_d = burst_cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= ARB_IDLE;
            addr_sel_q  <= 2'b00;
            data_sel_q  <= 2'b00;
            burst_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            addr_sel_q  <= addr_sel_d;
            data_sel_q  <= data_sel_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign addr_sel  = addr_sel_q;
    assign data_sel  = data_sel_q;
    assign burst_cnt = burst_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ml_ahb_arb_port_0.sv
// tb_ml_ahb_arb_port_0
// Directed scenarios for the port-0 arbiter with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, so each check sees the result of the edge just taken.
module tb_ml_ahb_arb_port_0;
    import ml_ahb_pkg::*;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [1:0] req;
    logic [5:0] prio;
    logic [1:0] htrans_m0, htrans_m1;
    logic [2:0] hburst_m0, hburst_m1;
    logic       hmastlock_m0, hmastlock_m1;
    logic       HREADY;
    logic [1:0] addr_sel, data_sel;
    logic [3:0] burst_cnt;
    arb_state_e state_dbg;

    int total = 0;
    int bad   = 0;

    ml_ahb_arb_port_0 dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req          (req),
        .prio         (prio),
        .htrans_m0    (htrans_m0),
        .htrans_m1    (htrans_m1),
        .hburst_m0    (hburst_m0),
        .hburst_m1    (hburst_m1),
        .hmastlock_m0 (hmastlock_m0),
        .hmastlock_m1 (hmastlock_m1),
        .HREADY       (HREADY),
        .addr_sel     (addr_sel),
        .data_sel     (data_sel),
        .burst_cnt    (burst_cnt),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        req = 2'b00; prio = 6'd0;
        htrans_m0 = HTRANS_IDLE; htrans_m1 = HTRANS_IDLE;
        hburst_m0 = HBURST_SINGLE; hburst_m1 = HBURST_SINGLE;
        hmastlock_m0 = 1'b0; hmastlock_m1 = 1'b0;
        HREADY = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        HRESETn = 1'b0;
        tick();
        tick();
        HRESETn = 1'b1;
    endtask

    // Selects must never be 11 at any point of the run.
    always @(negedge HCLK) begin
        if (HRESETn === 1'b1) begin
            total++;
            if (addr_sel === 2'b11 || data_sel === 2'b11) begin
                bad++;
                $display("FAIL onehot: addr_sel=%b data_sel=%b must not be 11", addr_sel, data_sel);
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        req = 2'b11;
        HRESETn = 1'b0;
        tick();
        tick();
        total++; if (addr_sel !== 2'b00) begin bad++; $display("FAIL rst_addr: got %b want 00", addr_sel); end
        total++; if (data_sel !== 2'b00) begin bad++; $display("FAIL rst_data: got %b want 00", data_sel); end
        total++; if (burst_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", burst_cnt); end
        total++; if (state_dbg !== ARB_IDLE) begin bad++; $display("FAIL rst_state: got %0d want IDLE", state_dbg); end
        HRESETn = 1'b1;
        req = 2'b00;
        tick();
        total++; if (addr_sel !== 2'b00) begin bad++; $display("FAIL rst_noreq_addr: got %b want 00", addr_sel); end
    endtask

    task automatic test_arbitration();
        // Tie at 3/3 goes to master 0.
        do_reset();
        req = 2'b11; prio = {3'd3, 3'd3};
        tick();
        total++; if (addr_sel !== 2'b01) begin bad++; $display("FAIL arb_tie: got %b want 01", addr_sel); end
        total++; if (state_dbg !== ARB_OWNED) begin bad++; $display("FAIL arb_state: got %0d want OWNED", state_dbg); end
        // Master 1 strictly better.
        do_reset();
        req = 2'b11; prio = {3'd2, 3'd3};
        tick();
        total++; if (addr_sel !== 2'b10) begin bad++; $display("FAIL arb_m1_better: got %b want 10", addr_sel); end
        // Only master 0 requests although master 1 has the better priority.
        do_reset();
        req = 2'b01; prio = {3'd0, 3'd7};
        tick();
        total++; if (addr_sel !== 2'b01) begin bad++; $display("FAIL arb_m0_only: got %b want 01", addr_sel); end
        // Only master 1 requests with the worse priority.
        do_reset();
        req = 2'b10; prio = {3'd7, 3'd0};
        tick();
        total++; if (addr_sel !== 2'b10) begin bad++; $display("FAIL arb_m1_only: got %b want 10", addr_sel); end
    endtask

    task automatic test_incr4_hold();
        do_reset();
        req = 2'b01; prio = {3'd5, 3'd5};
        tick();
        total++; if (addr_sel !== 2'b01) begin bad++; $display("FAIL i4_grant: got %b want 01", addr_sel); end
        htrans_m0 = HTRANS_NONSEQ; hburst_m0 = HBURST_INCR4;
        tick();
        total++; if (burst_cnt !== 4'd3) begin bad++; $display("FAIL i4_load: got %0d want 3", burst_cnt); end
        total++; if (data_sel !== 2'b01) begin bad++; $display("FAIL i4_data1: got %b want 01", data_sel); end
        // Master 1 asks with top priority during beat 2.
        htrans_m0 = HTRANS_SEQ; req = 2'b11; prio = {3'd0, 3'd5};
        tick();
        total++; if (addr_sel !== 2'b01 || burst_cnt !== 4'd2) begin bad++; $display("FAIL i4_beat2: got addr=%b cnt=%0d want addr=01 cnt=2", addr_sel, burst_cnt); end
        tick();
        total++; if (addr_sel !== 2'b01 || burst_cnt !== 4'd1) begin bad++; $display("FAIL i4_beat3: got addr=%b cnt=%0d want addr=01 cnt=1", addr_sel, burst_cnt); end
        tick();
        total++; if (addr_sel !== 2'b10) begin bad++; $display("FAIL i4_handover: got %b want 10", addr_sel); end
        total++; if (data_sel !== 2'b01 || burst_cnt !== 4'd0) begin bad++; $display("FAIL i4_last: got data=%b cnt=%0d want data=01 cnt=0", data_sel, burst_cnt); end
        htrans_m0 = HTRANS_IDLE;
        tick();
        total++; if (data_sel !== 2'b00 || addr_sel !== 2'b10) begin bad++; $display("FAIL i4_after: got data=%b addr=%b want data=00 addr=10", data_sel, addr_sel); end
    endtask

    task automatic test_hready_stall();
        do_reset();
        req = 2'b01;
        tick();
        htrans_m0 = HTRANS_NONSEQ; hburst_m0 = HBURST_INCR8;
        tick();
        total++; if (burst_cnt !== 4'd7) begin bad++; $display("FAIL st_load: got %0d want 7", burst_cnt); end
        htrans_m0 = HTRANS_SEQ;
        tick();
        total++; if (burst_cnt !== 4'd6) begin bad++; $display("FAIL st_dec: got %0d want 6", burst_cnt); end
        HREADY = 1'b0; req = 2'b11; prio = {3'd0, 3'd4};
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (addr_sel !== 2'b01 || data_sel !== 2'b01 || burst_cnt !== 4'd6) begin
                bad++;
                $display("FAIL st_hold%0d: got addr=%b data=%b cnt=%0d want addr=01 data=01 cnt=6", i, addr_sel, data_sel, burst_cnt);
            end
        end
        HREADY = 1'b1;
        tick();
        total++; if (burst_cnt !== 4'd5 || addr_sel !== 2'b01) begin bad++; $display("FAIL st_resume: got cnt=%0d addr=%b want cnt=5 addr=01", burst_cnt, addr_sel); end
    endtask

    task automatic test_reset_mid_incr8();
        do_reset();
        req = 2'b01;
        tick();
        htrans_m0 = HTRANS_NONSEQ; hburst_m0 = HBURST_INCR8;
        tick();
        htrans_m0 = HTRANS_SEQ;
        tick();
        tick();
        total++; if (burst_cnt !== 4'd5) begin bad++; $display("FAIL r8_beat3: got %0d want 5", burst_cnt); end
        HRESETn = 1'b0;
        tick();
        total++;
        if (addr_sel !== 2'b00 || data_sel !== 2'b00 || burst_cnt !== 4'd0) begin
            bad++;
            $display("FAIL r8_reset: got addr=%b data=%b cnt=%0d want 00 00 0", addr_sel, data_sel, burst_cnt);
        end
        HRESETn = 1'b1;
    endtask

    task automatic test_lock();
        do_reset();
        req = 2'b10; prio = {3'd7, 3'd0};
        tick();
        total++; if (addr_sel !== 2'b10) begin bad++; $display("FAIL lk_grant: got %b want 10", addr_sel); end
        req = 2'b11; htrans_m1 = HTRANS_NONSEQ; hburst_m1 = HBURST_SINGLE; hmastlock_m1 = 1'b1;
        tick();
        total++; if (addr_sel !== 2'b10 || data_sel !== 2'b10) begin bad++; $display("FAIL lk_single1: got addr=%b data=%b want 10 10", addr_sel, data_sel); end
        tick();
        total++; if (addr_sel !== 2'b10 || data_sel !== 2'b10) begin bad++; $display("FAIL lk_single2: got addr=%b data=%b want 10 10", addr_sel, data_sel); end
        // Idle while still locked keeps the bus.
        htrans_m1 = HTRANS_IDLE;
        tick();
        total++; if (addr_sel !== 2'b10 || data_sel !== 2'b00) begin bad++; $display("FAIL lk_idle: got addr=%b data=%b want 10 00", addr_sel, data_sel); end
        hmastlock_m1 = 1'b0;
        tick();
        total++; if (addr_sel !== 2'b01) begin bad++; $display("FAIL lk_release: got %b want 01", addr_sel); end
    endtask

    task automatic test_incr_release();
        do_reset();
        req = 2'b01;
        tick();
        htrans_m0 = HTRANS_NONSEQ; hburst_m0 = HBURST_INCR;
        tick();
        total++; if (data_sel !== 2'b01 || burst_cnt !== 4'd0) begin bad++; $display("FAIL inc_first: got data=%b cnt=%0d want 01 0", data_sel, burst_cnt); end
        htrans_m0 = HTRANS_SEQ; req = 2'b11; prio = {3'd0, 3'd6};
        tick();
        total++; if (addr_sel !== 2'b01) begin bad++; $display("FAIL inc_hold: got %b want 01", addr_sel); end
        req = 2'b00;
        tick();
        total++; if (addr_sel !== 2'b01 || data_sel !== 2'b01) begin bad++; $display("FAIL inc_lastbeat: got addr=%b data=%b want 01 01", addr_sel, data_sel); end
        htrans_m0 = HTRANS_IDLE;
        tick();
        total++;
        if (state_dbg !== ARB_IDLE || addr_sel !== 2'b00 || data_sel !== 2'b00) begin
            bad++;
            $display("FAIL inc_release: got state=%0d addr=%b data=%b want IDLE 00 00", state_dbg, addr_sel, data_sel);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        HRESETn = 1'b0;
        test_reset();
        test_arbitration();
        test_incr4_hold();
        test_hready_stall();
        test_reset_mid_incr8();
        test_lock();
        test_incr_release();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
